// File: rtl/snoop_write_queue.sv
// snoop_write_queue: captures 68000 writes into the frame-buffer window,
// queues them in a small FIFO and drains them byte-wise into VRAM during
// sequencer write slots. All state updates on the falling edge of pixClock.
module snoop_write_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [13:0] FB_OFFSET = 14'h1380,
  parameter int unsigned LAST_SLOT = 6
) (
  input  logic                     nReset,
  input  logic                     pixClock,
  input  logic [2:0]               seq,
  input  logic [22:0]              cpuAddr,
  input  logic [15:0]              cpuData,
  input  logic                     ncpuAS,
  input  logic                     ncpuUDS,
  input  logic                     ncpuLDS,
  input  logic                     cpuRnW,
  input  logic [2:0]               ramSize,
  output logic [14:0]              vramAddr,
  output logic [7:0]               vramDataOut,
  output logic                     nvramWE,
  output logic [$clog2(DEPTH):0]   fifoLevel,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [13:0] wAddr;
    logic        hi;
    logic        lo;
    logic [15:0] data;
  } snoopEntryT;

  typedef enum logic {C_IDLE, C_WAIT} capStateT;
  typedef enum logic [1:0] {D_IDLE, D_LO, D_HI} drainStateT;

  capStateT   capState, capNext;
  drainStateT drainState, drainNext;

  snoopEntryT             mem [DEPTH];
  logic [PTR_W-1:0]       wrPtr, rdPtr;
  snoopEntryT             head, newEntry;

  logic        bufSel, cpuHit, push, accept, pop, notEmpty;
  logic        singleOk, dualOk;
  logic        weNext;
  logic [14:0] addrNext;
  logic [7:0]  dataNext;

  // Frame-buffer window decode and the entry a CPU write would produce
  always_comb begin
    bufSel = (cpuAddr[22:21] == 2'b00) && (cpuAddr[20:18] == ramSize) &&
             (cpuAddr[17:14] == 4'hF);
    cpuHit = !ncpuAS && bufSel && !cpuRnW && (!ncpuUDS || !ncpuLDS);
    newEntry.wAddr = cpuAddr[13:0] - FB_OFFSET;
    newEntry.hi    = !ncpuUDS;
    newEntry.lo    = !ncpuLDS;
    newEntry.data  = cpuData;
  end

  // Capture FSM: one push per CPU bus cycle
  always_comb begin
    capNext = capState;
    push    = 1'b0;
    unique case (capState)
      C_IDLE: if (cpuHit) begin
        push    = 1'b1;
        capNext = C_WAIT;
      end
      C_WAIT: if (ncpuUDS && ncpuLDS) capNext = C_IDLE;
      default: capNext = C_IDLE;
    endcase
  end

  // A full FIFO still accepts a write when the head leaves on the same edge
  always_comb begin
    accept = push && ((fifoLevel < LVL_W'(DEPTH)) || pop);
  end

  // Drain FSM: next state plus next values of the registered VRAM outputs
  always_comb begin
    head      = mem[rdPtr];
    notEmpty  = (fifoLevel != '0);
    singleOk  = 32'(seq) <= LAST_SLOT;
    dualOk    = (32'(seq) + 32'd1) <= LAST_SLOT;
    drainNext = drainState;
    pop       = 1'b0;
    weNext    = 1'b1;
    addrNext  = vramAddr;
    dataNext  = 8'h00;
    unique case (drainState)
      D_IDLE: begin
        if (notEmpty && ((head.hi && head.lo && dualOk) ||
                         (head.lo && !head.hi && singleOk))) begin
          drainNext = D_LO;
          weNext    = 1'b0;
          addrNext  = {head.wAddr, 1'b1};
          dataNext  = head.data[7:0];
        end else if (notEmpty && head.hi && !head.lo && singleOk) begin
          drainNext = D_HI;
          weNext    = 1'b0;
          addrNext  = {head.wAddr, 1'b0};
          dataNext  = head.data[15:8];
        end
      end
      D_LO: begin
        if (head.hi) begin
          drainNext = D_HI;
          weNext    = 1'b0;
          addrNext  = {head.wAddr, 1'b0};
          dataNext  = head.data[15:8];
        end else begin
          drainNext = D_IDLE;
          pop       = 1'b1;
        end
      end
      D_HI: begin
        drainNext = D_IDLE;
        pop       = 1'b1;
      end
      default: drainNext = D_IDLE;
    endcase
  end

  // State and VRAM output registers
  always_ff @(negedge pixClock or negedge nReset) begin
    if (!nReset) begin
      capState    <= C_IDLE;
      drainState  <= D_IDLE;
      nvramWE     <= 1'b1;
      vramAddr    <= '0;
      vramDataOut <= '0;
    end else begin
      capState    <= capNext;
      drainState  <= drainNext;
      nvramWE     <= weNext;
      vramAddr    <= addrNext;
      vramDataOut <= dataNext;
    end
  end

  // FIFO storage, pointers, level and sticky overflow
  always_ff @(negedge pixClock or negedge nReset) begin
    if (!nReset) begin
      mem       <= '{default: '0};
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoLevel <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        mem[wrPtr] <= newEntry;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (pop) rdPtr <= rdPtr + PTR_W'(1);
      if (accept && !pop)      fifoLevel <= fifoLevel + LVL_W'(1);
      else if (!accept && pop) fifoLevel <= fifoLevel - LVL_W'(1);
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_snoop_write_queue.sv
// Directed self-checking bench for snoop_write_queue (DEPTH=4 defaults).
module tb_snoop_write_queue;

  logic        nReset;
  logic        pixClock;
  logic [2:0]  seq;
  logic [22:0] cpuAddr;
  logic [15:0] cpuData;
  logic        ncpuAS, ncpuUDS, ncpuLDS, cpuRnW;
  logic [2:0]  ramSize;
  logic [14:0] vramAddr;
  logic [7:0]  vramDataOut;
  logic        nvramWE;
  logic [2:0]  fifoLevel;
  logic        overflow;

  int assertCount = 0;
  int failCount   = 0;

  snoop_write_queue dut (
    .nReset      (nReset),
    .pixClock    (pixClock),
    .seq         (seq),
    .cpuAddr     (cpuAddr),
    .cpuData     (cpuData),
    .ncpuAS      (ncpuAS),
    .ncpuUDS     (ncpuUDS),
    .ncpuLDS     (ncpuLDS),
    .cpuRnW      (cpuRnW),
    .ramSize     (ramSize),
    .vramAddr    (vramAddr),
    .vramDataOut (vramDataOut),
    .nvramWE     (nvramWE),
    .fifoLevel   (fifoLevel),
    .overflow    (overflow)
  );

  initial pixClock = 1'b0;
  always #20 pixClock = ~pixClock;

  // Count one comparison and report it if it disagrees
  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active (falling) edge
  task automatic step();
    @(negedge pixClock);
    #1;
  endtask

  task automatic busIdle();
    ncpuAS  = 1'b1;
    ncpuUDS = 1'b1;
    ncpuLDS = 1'b1;
    cpuRnW  = 1'b1;
  endtask

  task automatic busDrive(input logic [22:0] a, input logic [15:0] d, input logic rnw,
                          input logic nUds, input logic nLds);
    cpuAddr = a;
    cpuData = d;
    cpuRnW  = rnw;
    ncpuAS  = 1'b0;
    ncpuUDS = nUds;
    ncpuLDS = nLds;
  endtask

  task automatic wordWrite(input logic [22:0] a, input logic [15:0] d);
    busDrive(a, d, 1'b0, 1'b0, 1'b0);
    step();
    busIdle();
    step();
  endtask

  task automatic checkStrobe(input string tag, input logic [14:0] a, input logic [7:0] d);
    checkEq({tag, " we"},   32'(nvramWE), 0);
    checkEq({tag, " addr"}, 32'(vramAddr), 32'(a));
    checkEq({tag, " data"}, 32'(vramDataOut), 32'(d));
  endtask

  logic [22:0] t5Addr [6];
  logic        t5RnW  [6];
  logic        t5nStb [6];
  logic [2:0]  t5Ram  [6];

  initial begin
    nReset  = 1'b0;
    seq     = 3'd0;
    ramSize = 3'd7;
    cpuAddr = '0;
    cpuData = '0;
    busIdle();

    // Reset state
    step();
    checkEq("rst we",       32'(nvramWE), 1);
    checkEq("rst addr",     32'(vramAddr), 0);
    checkEq("rst data",     32'(vramDataOut), 0);
    checkEq("rst level",    32'(fifoLevel), 0);
    checkEq("rst overflow", 32'(overflow), 0);
    nReset = 1'b1;
    step();

    // T1: word write, lo byte then hi byte on consecutive edges
    busDrive(23'h1FD380, 16'hA55A, 1'b0, 1'b0, 1'b0);
    step();
    checkEq("t1 push level", 32'(fifoLevel), 1);
    checkEq("t1 push we",    32'(nvramWE), 1);
    busIdle();
    step();
    checkStrobe("t1 lo", 15'h0001, 8'h5A);
    step();
    checkStrobe("t1 hi", 15'h0000, 8'hA5);
    step();
    checkEq("t1 idle we",   32'(nvramWE), 1);
    checkEq("t1 idle data", 32'(vramDataOut), 0);
    checkEq("t1 idle addr", 32'(vramAddr), 0);
    checkEq("t1 level",     32'(fifoLevel), 0);

    // T2a: UDS-only write in the last single-byte slot
    seq = 3'd6;
    busDrive(23'h1FD380, 16'hC33C, 1'b0, 1'b0, 1'b1);
    step();
    busIdle();
    step();
    checkStrobe("t2a hi", 15'h0000, 8'hC3);
    step();
    checkEq("t2a idle we", 32'(nvramWE), 1);
    checkEq("t2a level",   32'(fifoLevel), 0);

    // T2b: word write at seq=6 waits for the slot to wrap
    busDrive(23'h1FD381, 16'h1234, 1'b0, 1'b0, 1'b0);
    step();
    busIdle();
    step();
    checkEq("t2b hold6 we",    32'(nvramWE), 1);
    checkEq("t2b hold6 level", 32'(fifoLevel), 1);
    seq = 3'd7;
    step();
    checkEq("t2b hold7 we", 32'(nvramWE), 1);
    seq = 3'd0;
    step();
    checkStrobe("t2b lo", 15'h0003, 8'h34);
    step();
    checkStrobe("t2b hi", 15'h0002, 8'h12);
    step();
    checkEq("t2b idle we", 32'(nvramWE), 1);
    checkEq("t2b level",   32'(fifoLevel), 0);

    // T3: overfill with drain held off, then drain in order
    seq = 3'd7;
    for (int i = 0; i < 5; i++) wordWrite(23'h1FD380 + 23'(i), 16'h1000 + 16'(i));
    checkEq("t3 full level", 32'(fifoLevel), 4);
    checkEq("t3 overflow",   32'(overflow), 1);
    checkEq("t3 held we",    32'(nvramWE), 1);
    seq = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkStrobe($sformatf("t3 e%0d lo", i), 15'(2 * i + 1), 8'(i));
      step();
      checkStrobe($sformatf("t3 e%0d hi", i), 15'(2 * i), 8'h10);
      step();
      checkEq($sformatf("t3 e%0d gap we", i), 32'(nvramWE), 1);
    end
    checkEq("t3 empty level", 32'(fifoLevel), 0);
    checkEq("t3 sticky ovf",  32'(overflow), 1);
    step();
    checkEq("t3 no extra we", 32'(nvramWE), 1);

    // Reset clears the sticky overflow
    nReset = 1'b0;
    step();
    checkEq("rst2 overflow", 32'(overflow), 0);
    nReset = 1'b1;
    step();

    // T4: full FIFO, pop and push on the same edge
    seq = 3'd7;
    for (int i = 0; i < 4; i++) wordWrite(23'h1FD390 + 23'(i), 16'h2000 + 16'(i));
    checkEq("t4 full level", 32'(fifoLevel), 4);
    seq = 3'd0;
    step();
    checkStrobe("t4 e0 lo", 15'h0021, 8'h00);
    step();
    checkStrobe("t4 e0 hi", 15'h0020, 8'h20);
    busDrive(23'h1FD394, 16'h2004, 1'b0, 1'b0, 1'b0);
    step();
    checkEq("t4 same-edge level", 32'(fifoLevel), 4);
    checkEq("t4 same-edge ovf",   32'(overflow), 0);
    busIdle();
    for (int i = 1; i < 5; i++) begin
      step();
      checkStrobe($sformatf("t4 e%0d lo", i), 15'(2 * (16 + i) + 1), 8'(i));
      step();
      checkStrobe($sformatf("t4 e%0d hi", i), 15'(2 * (16 + i)), 8'h20);
      step();
    end
    checkEq("t4 empty level", 32'(fifoLevel), 0);
    checkEq("t4 final ovf",   32'(overflow), 0);

    // T5: accesses that must be ignored
    t5Addr = '{23'h1F8000, 23'h1F8000, 23'h1FD380, 23'h1FD380, 23'h1FD380, 23'h5FD380};
    t5RnW  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    t5nStb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    t5Ram  = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd3, 3'd7};
    for (int i = 0; i < 6; i++) begin
      ramSize = t5Ram[i];
      busDrive(t5Addr[i], 16'hBEEF, t5RnW[i], t5nStb[i], t5nStb[i]);
      step();
      checkEq($sformatf("t5 v%0d level", i), 32'(fifoLevel), 0);
      busIdle();
      step();
      checkEq($sformatf("t5 v%0d we", i), 32'(nvramWE), 1);
    end
    ramSize = 3'd7;

    // T6: reset in the middle of a strobe with two entries queued
    seq = 3'd7;
    wordWrite(23'h1FD3A0, 16'h3011);
    wordWrite(23'h1FD3A1, 16'h3022);
    checkEq("t6 level", 32'(fifoLevel), 2);
    seq = 3'd0;
    step();
    checkStrobe("t6 lo", 15'h0041, 8'h11);
    #5 nReset = 1'b0;
    #1;
    checkEq("t6 rst we",    32'(nvramWE), 1);
    checkEq("t6 rst level", 32'(fifoLevel), 0);
    checkEq("t6 rst addr",  32'(vramAddr), 0);
    step();
    step();
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checkEq($sformatf("t6 post%0d we", i), 32'(nvramWE), 1);
    end
    checkEq("t6 post level", 32'(fifoLevel), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
